tmr_vote_monitor: RTL and testbench

Word-wide majority voter and upset monitor for triplicated register groups. It consumes the three replica copies of a WIDTH-bit word, votes bit by bit, and registers the voted result for downstream logic. It reports which replicas disagreed through a one-entry valid/ready event buffer and, optionally, through per-replica saturating upset counters. The block sits directly downstream of the triplicated storage flops and is the point where silent replica upsets become observable.

---
 rtl/tmr_vote_monitor.sv | 163 ++++++++++++++++
 tb/tb_tmr_vote_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_vote_monitor.sv
// Bitwise majority voter for triplicated words with a one-entry upset event buffer.
// Optional per-replica saturating upset counters are built when TMR_MON_COUNTERS_EN is defined.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_EMPTY | no pending event; the next mismatch is captured
//  S_FULL  | event held stable on evt_*; later mismatches are dropped
//          | and flagged as overflow until the event is accepted
module tmr_vote_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [2:0]       evt_mask,
   output logic             evt_multi,
   output logic             evt_overflow,
   input  logic             cnt_clr
`ifdef TMR_MON_COUNTERS_EN
   ,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c
`endif
);

   typedef enum logic {S_EMPTY, S_FULL} evt_state_e;

   logic [WIDTH-1:0] vote;
   logic [2:0]       mism;
   logic             multi;

   evt_state_e       evt_state_q, evt_state_d;
   logic [2:0]       evt_mask_q, evt_mask_d;
   logic             evt_multi_q, evt_multi_d;
   logic             evt_ovf_q, evt_ovf_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_err_q, out_err_d;

   always_comb begin
      vote  = (in_a & in_b) | (in_b & in_c) | (in_c & in_a);
      mism  = '0;
      if (in_valid) begin
         mism = {in_c != vote, in_b != vote, in_a != vote};
      end
      // a degraded vote: two replicas each lost a different bit
      multi = (mism[0] & mism[1]) | (mism[1] & mism[2]) | (mism[0] & mism[2]);

      out_valid_d = in_valid;
      out_data_d  = in_valid ? vote : out_data_q;
      out_err_d   = |mism;
   end

   always_comb begin
      evt_state_d = evt_state_q;
      evt_mask_d  = evt_mask_q;
      evt_multi_d = evt_multi_q;
      evt_ovf_d   = evt_ovf_q;
      case (evt_state_q)
         S_EMPTY: begin
            if (|mism) begin
               evt_state_d = S_FULL;
               evt_mask_d  = mism;
               evt_multi_d = multi;
               evt_ovf_d   = 1'b0;
            end
         end
         S_FULL: begin
            if (evt_ready) begin
               if (|mism) begin
                  evt_mask_d  = mism;
                  evt_multi_d = multi;
                  evt_ovf_d   = 1'b0;
               end else begin
                  evt_state_d = S_EMPTY;
                  evt_mask_d  = '0;
                  evt_multi_d = 1'b0;
                  evt_ovf_d   = 1'b0;
               end
            end else if (|mism) begin
               evt_ovf_d = 1'b1;
            end
         end
         default: evt_state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_state_q <= S_EMPTY;
         evt_mask_q  <= '0;
         evt_multi_q <= 1'b0;
         evt_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         evt_state_q <= evt_state_d;
         evt_mask_q  <= evt_mask_d;
         evt_multi_q <= evt_multi_d;
         evt_ovf_q   <= evt_ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_err      = out_err_q;
   assign evt_valid    = (evt_state_q == S_FULL);
   assign evt_mask     = evt_mask_q;
   assign evt_multi    = evt_multi_q;
   assign evt_overflow = evt_ovf_q;

`ifdef TMR_MON_COUNTERS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   // clear wins over the old count but not over an upset in the same cycle
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr) begin
            cnt_d[i] = mism[i] ? CNT_W'(1) : '0;
         end else if (mism[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign cnt_a = cnt_q[0];
   assign cnt_b = cnt_q[1];
   assign cnt_c = cnt_q[2];
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: vector table for vote/event behaviour,
// plus hand sequences for reset, counter saturation/clear and reset mid-event.
module tb_tmr_vote_monitor;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_a, in_b, in_c;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_err;
   logic             evt_valid;
   logic             evt_ready;
   logic [2:0]       evt_mask;
   logic             evt_multi;
   logic             evt_overflow;
   logic             cnt_clr;
`ifdef TMR_MON_COUNTERS_EN
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
`endif

   always #5 clk = ~clk;

   tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_c         (in_c),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_err      (out_err),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_mask     (evt_mask),
      .evt_multi    (evt_multi),
      .evt_overflow (evt_overflow),
      .cnt_clr      (cnt_clr)
`ifdef TMR_MON_COUNTERS_EN
      ,
      .cnt_a        (cnt_a),
      .cnt_b        (cnt_b),
      .cnt_c        (cnt_c)
`endif
   );

   typedef struct {
      logic       iv;
      logic [7:0] a, b, c;
      logic       rdy;
      logic       e_ov;
      logic [7:0] e_dat;
      logic       e_err;
      logic       e_ev;
      logic [2:0] e_msk;
      logic       e_mul;
      logic       e_ovf;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic vec_t mk(logic iv, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                               logic rdy, logic ov, logic [7:0] dat, logic err,
                               logic ev, logic [2:0] msk, logic mul, logic ovf);
      vec_t v;
      v.iv = iv; v.a = a; v.b = b; v.c = c; v.rdy = rdy;
      v.e_ov = ov; v.e_dat = dat; v.e_err = err; v.e_ev = ev;
      v.e_msk = msk; v.e_mul = mul; v.e_ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic rdy, input logic clr);
      in_valid  = iv;
      in_a      = a;
      in_b      = b;
      in_c      = c;
      evt_ready = rdy;
      cnt_clr   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".out_valid"},    32'(out_valid),    32'd0);
      chk({tag, ".out_data"},     32'(out_data),     32'd0);
      chk({tag, ".out_err"},      32'(out_err),      32'd0);
      chk({tag, ".evt_valid"},    32'(evt_valid),    32'd0);
      chk({tag, ".evt_mask"},     32'(evt_mask),     32'd0);
      chk({tag, ".evt_multi"},    32'(evt_multi),    32'd0);
      chk({tag, ".evt_overflow"}, 32'(evt_overflow), 32'd0);
`ifdef TMR_MON_COUNTERS_EN
      chk({tag, ".cnt_a"}, 32'(cnt_a), 32'd0);
      chk({tag, ".cnt_b"}, 32'(cnt_b), 32'd0);
      chk({tag, ".cnt_c"}, 32'(cnt_c), 32'd0);
`endif
   endtask

   vec_t vecs [13];

   initial begin
      //           iv  a      b      c      rdy ov  dat    err ev msk     mul ovf
      vecs[0]  = mk(1, 8'hA5, 8'hA5, 8'hA5, 0,  1, 8'hA5, 0,  0, 3'b000, 0,  0);
      vecs[1]  = mk(1, 8'hA5, 8'hA4, 8'hA5, 0,  1, 8'hA5, 1,  1, 3'b010, 0,  0);
      vecs[2]  = mk(0, 8'h00, 8'h00, 8'h00, 0,  0, 8'hA5, 0,  1, 3'b010, 0,  0);
      vecs[3]  = mk(1, 8'h01, 8'h02, 8'h00, 0,  1, 8'h00, 1,  1, 3'b010, 0,  1);
      vecs[4]  = mk(1, 8'hFF, 8'hFF, 8'hFE, 0,  1, 8'hFF, 1,  1, 3'b010, 0,  1);
      vecs[5]  = mk(1, 8'h33, 8'h33, 8'h33, 1,  1, 8'h33, 0,  0, 3'b000, 0,  0);
      vecs[6]  = mk(1, 8'h01, 8'h02, 8'h00, 0,  1, 8'h00, 1,  1, 3'b011, 1,  0);
      vecs[7]  = mk(1, 8'h00, 8'h00, 8'h80, 0,  1, 8'h00, 1,  1, 3'b011, 1,  1);
      vecs[8]  = mk(1, 8'h10, 8'h00, 8'h00, 1,  1, 8'h00, 1,  1, 3'b001, 0,  0);
      vecs[9]  = mk(0, 8'h10, 8'h00, 8'h00, 0,  0, 8'h00, 0,  1, 3'b001, 0,  0);
      vecs[10] = mk(1, 8'h5A, 8'h5A, 8'h5A, 1,  1, 8'h5A, 0,  0, 3'b000, 0,  0);
      vecs[11] = mk(0, 8'hFF, 8'h00, 8'h00, 1,  0, 8'h5A, 0,  0, 3'b000, 0,  0);
      vecs[12] = mk(1, 8'h00, 8'hC3, 8'hC3, 1,  1, 8'hC3, 1,  1, 3'b001, 0,  0);

      rst = 1'b1;
      drive(1, 8'hFF, 8'h00, 8'h0F, 1, 0);
      drive(1, 8'hFF, 8'h00, 8'h0F, 1, 0);
      chk_reset_vals("reset");
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rdy, 1'b0);
         chk($sformatf("v%0d.out_valid", i),    32'(out_valid),    32'(vecs[i].e_ov));
         chk($sformatf("v%0d.out_data", i),     32'(out_data),     32'(vecs[i].e_dat));
         chk($sformatf("v%0d.out_err", i),      32'(out_err),      32'(vecs[i].e_err));
         chk($sformatf("v%0d.evt_valid", i),    32'(evt_valid),    32'(vecs[i].e_ev));
         chk($sformatf("v%0d.evt_mask", i),     32'(evt_mask),     32'(vecs[i].e_msk));
         chk($sformatf("v%0d.evt_multi", i),    32'(evt_multi),    32'(vecs[i].e_mul));
         chk($sformatf("v%0d.evt_overflow", i), 32'(evt_overflow), 32'(vecs[i].e_ovf));
      end

`ifdef TMR_MON_COUNTERS_EN
      drive(0, 8'h00, 8'h00, 8'h00, 1, 1);
      chk("clr.cnt_a", 32'(cnt_a), 32'd0);
      chk("clr.cnt_b", 32'(cnt_b), 32'd0);
      chk("clr.cnt_c", 32'(cnt_c), 32'd0);
      for (int i = 0; i < 20; i++) begin
         drive(1, 8'h00, 8'h00, 8'h04, 1, 0);
         if (i == 14) chk("sat.cnt_c_at15", 32'(cnt_c), 32'd15);
      end
      chk("sat.cnt_c", 32'(cnt_c), 32'd15);
      chk("sat.cnt_a", 32'(cnt_a), 32'd0);
      drive(1, 8'h00, 8'h00, 8'h04, 1, 1);
      chk("clrinc.cnt_c", 32'(cnt_c), 32'd1);
      chk("clrinc.cnt_a", 32'(cnt_a), 32'd0);
      chk("clrinc.cnt_b", 32'(cnt_b), 32'd0);
`endif

      // build a pending event with cnt_a = 3, then reset in the middle of it
      drive(1, 8'h01, 8'h00, 8'h00, 0, 1);
      drive(1, 8'h01, 8'h00, 8'h00, 0, 0);
      drive(1, 8'h01, 8'h00, 8'h00, 0, 0);
      chk("pre_rst.evt_valid", 32'(evt_valid), 32'd1);
      chk("pre_rst.out_err",   32'(out_err),   32'd1);
`ifdef TMR_MON_COUNTERS_EN
      chk("pre_rst.cnt_a", 32'(cnt_a), 32'd3);
`endif
      rst = 1'b1;
      drive(1, 8'h01, 8'h00, 8'h00, 0, 0);
      rst = 1'b0;
      chk_reset_vals("mid_rst");

      drive(0, 8'h00, 8'h00, 8'h00, 0, 0);
      chk("post_rst.evt_valid", 32'(evt_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
